// File: rtl/retry_inorder_end_if.sv
// Bundle of all channels seen by retry_inorder_end: DMR-checked results in,
// in-order results out, and the retry request channel back to retry_start.
interface retry_inorder_end_if #(
  parameter type DataType = logic,
  parameter int  IDSize   = 4
);
  DataType           data_i;
  logic [IDSize-1:0] id_i;
  logic              needs_retry_i;
  logic              valid_i;
  logic              ready_o;

  DataType           data_o;
  logic              valid_o;
  logic              ready_i;

  logic [IDSize-1:0] retry_id_o;
  logic              retry_valid_o;
  logic              retry_ready_i;

  logic              duplicate_o;

  // The block's own view.
  modport slave (
    input  data_i, id_i, needs_retry_i, valid_i, ready_i, retry_ready_i,
    output ready_o, data_o, valid_o, retry_id_o, retry_valid_o, duplicate_o
  );

  // The surroundings: time_DMR_end, downstream consumer and retry_start.
  modport master (
    output data_i, id_i, needs_retry_i, valid_i, ready_i, retry_ready_i,
    input  ready_o, data_o, valid_o, retry_id_o, retry_valid_o, duplicate_o
  );
endinterface

// File: rtl/retry_inorder_end.sv
// Terminating stage of the time-DMR retry loop: failed IDs go back to
// retry_start, good results wait in an ID-indexed buffer and leave in ID order.
module retry_inorder_end #(
  parameter type DataType = logic,
  parameter int  IDSize   = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  retry_inorder_end_if.slave  bus
);

  localparam int Depth = 1 << IDSize;
  typedef logic [IDSize-1:0] id_t;

  logic [Depth-1:0] occ_q, occ_d;
  id_t              expected_id_q, expected_id_d;
  id_t              retry_id_q, retry_id_d;
  logic             retry_valid_q, retry_valid_d;
  logic             duplicate_q, duplicate_d;
  DataType          mem_q [Depth];
  DataType          mem_d [Depth];

  logic release_head;
  logic head_clash;
  logic good_ready;
  logic retry_ready;
  logic write_good;
  logic accept_retry;

  assign release_head = occ_q[expected_id_q] && bus.ready_i;
  // A write into the slot being released this cycle must wait one cycle.
  assign head_clash   = release_head && (bus.id_i == expected_id_q);
  assign good_ready   = !occ_q[bus.id_i] && !head_clash;
  assign retry_ready  = !retry_valid_q || bus.retry_ready_i;
  assign write_good   = bus.valid_i && !bus.needs_retry_i && good_ready;
  assign accept_retry = bus.valid_i && bus.needs_retry_i && retry_ready;

  assign bus.ready_o       = bus.needs_retry_i ? retry_ready : good_ready;
  assign bus.valid_o       = occ_q[expected_id_q];
  assign bus.data_o        = mem_q[expected_id_q];
  assign bus.retry_valid_o = retry_valid_q;
  assign bus.retry_id_o    = retry_id_q;
  assign bus.duplicate_o   = duplicate_q;

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_slot
      logic hit_write;
      logic hit_release;
      assign hit_write   = write_good && (bus.id_i == id_t'(gi));
      assign hit_release = release_head && (expected_id_q == id_t'(gi));
      assign occ_d[gi]   = (occ_q[gi] && !hit_release) || hit_write;
      assign mem_d[gi]   = hit_write ? bus.data_i : mem_q[gi];
    end
  endgenerate

  always_comb begin
    expected_id_d = expected_id_q;
    if (release_head) begin
      expected_id_d = expected_id_q + id_t'(1);
    end
  end

  // Single-entry retry register; accept-and-drain in one cycle reloads it.
  always_comb begin
    retry_valid_d = retry_valid_q;
    retry_id_d    = retry_id_q;
    if (accept_retry) begin
      retry_valid_d = 1'b1;
      retry_id_d    = bus.id_i;
    end else if (retry_valid_q && bus.retry_ready_i) begin
      retry_valid_d = 1'b0;
    end
  end

  always_comb begin
    duplicate_d = bus.valid_i && !bus.needs_retry_i && occ_q[bus.id_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q         <= '0;
      expected_id_q <= '0;
      retry_valid_q <= 1'b0;
      retry_id_q    <= '0;
      duplicate_q   <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      expected_id_q <= expected_id_d;
      retry_valid_q <= retry_valid_d;
      retry_id_q    <= retry_id_d;
      duplicate_q   <= duplicate_d;
    end
  end

  // Payload storage carries no reset; a slot is only visible while occupied.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_retry_inorder_end.sv
// Randomised and directed bench for retry_inorder_end with an in-order
// release model and a negedge monitor comparing against scoreboard queues.
module tb_retry_inorder_end;

  typedef struct {
    logic [3:0] id;
    logic [7:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  retry_inorder_end_if #(.DataType(logic [7:0]), .IDSize(4)) bus ();

  retry_inorder_end #(.DataType(logic [7:0]), .IDSize(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: results become releasable once every earlier ID is in.
  ent_t       exp_q[$];
  logic [7:0] pending[int];
  logic [3:0] rq[$];
  int         pool[$];
  int         push_ptr = 0;
  int         alloc_cnt = 0;
  int         rel_cnt = 0;
  bit         dup_prev = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit occ_m(int id);
    if (pending.exists(id)) return 1'b1;
    foreach (exp_q[k]) if (int'(exp_q[k].id) == id) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : monitor
    logic [3:0] id;
    bit occ_in, exp_rel, pred;
    int idx;
    if (rst_n) begin
      chk("valid_o", 32'(bus.valid_o), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0 && bus.valid_o)
        chk("data_o", 32'(bus.data_o), 32'(exp_q[0].data));
      chk("retry_valid_o", 32'(bus.retry_valid_o), 32'(rq.size() > 0));
      if (rq.size() > 0 && bus.retry_valid_o)
        chk("retry_id_o", 32'(bus.retry_id_o), 32'(rq[0]));
      chk("duplicate_o", 32'(bus.duplicate_o), 32'(dup_prev));

      id      = bus.id_i;
      occ_in  = occ_m(int'(id));
      exp_rel = (exp_q.size() > 0) && bus.ready_i;
      if (bus.needs_retry_i) pred = (rq.size() == 0) || bus.retry_ready_i;
      else pred = !occ_in && !(exp_rel && exp_q[0].id == id);
      chk("ready_o", 32'(bus.ready_o), 32'(pred));

      if (exp_rel) begin
        void'(exp_q.pop_front());
        rel_cnt++;
      end
      if (rq.size() > 0 && bus.retry_ready_i) void'(rq.pop_front());
      if (bus.valid_i && pred) begin
        if (bus.needs_retry_i) begin
          rq.push_back(id);
        end else begin
          pending[int'(id)] = bus.data_i;
          idx = -1;
          foreach (pool[k]) if (idx < 0 && pool[k] == int'(id)) idx = k;
          if (idx >= 0) pool.delete(idx);
          while (pending.exists(push_ptr)) begin
            exp_q.push_back('{id: 4'(push_ptr), data: pending[push_ptr]});
            pending.delete(push_ptr);
            push_ptr = (push_ptr + 1) & 15;
          end
        end
      end
      dup_prev = bus.valid_i && !bus.needs_retry_i && occ_in;
    end
  end

  task automatic drive(bit v, int id, bit nr, int d, bit rdy, bit rrdy);
    bus.valid_i       = v;
    bus.id_i          = 4'(id);
    bus.needs_retry_i = nr;
    bus.data_i        = 8'(d);
    bus.ready_i       = rdy;
    bus.retry_ready_i = rrdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    exp_q.delete(); pending.delete(); rq.delete(); pool.delete();
    push_ptr = 0; alloc_cnt = 0; rel_cnt = 0; dup_prev = 0;
    #1;
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_retry_valid_o", 32'(bus.retry_valid_o), 32'd0);
    chk("rst_retry_id_o", 32'(bus.retry_id_o), 32'd0);
    chk("rst_duplicate_o", 32'(bus.duplicate_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int id, r, guard;
    bit nr;
    bus.valid_i = 0; bus.id_i = 0; bus.needs_retry_i = 0; bus.data_i = 0;
    bus.ready_i = 1; bus.retry_ready_i = 1;
    do_reset();

    // In-order, no faults.
    for (int i = 0; i < 4; i++) drive(1, i, 0, 'hA0 + i, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    // Retry and reorder: 5 fails, 6/7 wait behind it.
    drive(1, 4, 0, 'hA4, 1, 1);
    drive(1, 5, 1, 'h00, 1, 1);
    drive(1, 6, 0, 'hA6, 1, 1);
    drive(1, 7, 0, 'hA7, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 5, 0, 'hA5, 1, 1);
    repeat (4) drive(0, 0, 0, 0, 1, 1);
    // Retry backpressure.
    drive(1, 8, 1, 0, 1, 0);
    drive(1, 9, 1, 0, 1, 0);
    drive(1, 9, 1, 0, 1, 0);
    drive(1, 9, 1, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(1, 8, 0, 'hB8, 1, 1);
    drive(1, 9, 0, 'hB9, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 1, 1);

    // Duplicate while head-of-line blocked on ID3.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, i, 0, 'hC0 + i, 1, 1);
    drive(1, 5, 0, 'hC5, 1, 1);
    drive(1, 5, 0, 'hEE, 1, 1);
    drive(1, 5, 0, 'hEE, 1, 1);
    drive(1, 3, 0, 'hC3, 1, 1);
    drive(1, 4, 0, 'hC4, 1, 1);
    repeat (4) drive(0, 0, 0, 0, 1, 1);

    // Reset mid-stream with buffered results and a pending retry.
    do_reset();
    drive(1, 1, 0, 'hD1, 1, 0);
    drive(1, 2, 0, 'hD2, 1, 0);
    drive(1, 3, 1, 'h00, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    do_reset();
    drive(1, 0, 0, 'hD0, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 1, 1);

    // Downstream stall, full buffer, wrap of expected_id.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, i, 0, 'h10 + i, 0, 1);
    drive(1, 0, 0, 'hEE, 0, 1);
    drive(1, 0, 0, 'hEE, 0, 1);
    repeat (17) drive(0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 'h55, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 1, 1);

    // Randomised traffic with in-flight window of 16 IDs.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        drive(0, 0, 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end else if (r < 22 && (exp_q.size() > 0 || pending.num() > 0)) begin
        if (exp_q.size() > 0) id = int'(exp_q[$urandom_range(0, exp_q.size() - 1)].id);
        else void'(pending.first(id));
        drive(1, id, 0, $urandom_range(0, 255),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end else begin
        if ((pool.size() == 0 || $urandom_range(0, 1) == 1) && alloc_cnt - rel_cnt < 16) begin
          pool.push_back(alloc_cnt & 15);
          alloc_cnt++;
        end
        if (pool.size() > 0) begin
          id = pool[$urandom_range(0, pool.size() - 1)];
          nr = $urandom_range(0, 3) == 0;
          drive(1, id, nr, $urandom_range(0, 255),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end else begin
          drive(0, 0, 0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
      end
    end

    // Resend every outstanding ID cleanly until the stream drains.
    guard = 0;
    while ((pool.size() > 0 || exp_q.size() > 0 || rq.size() > 0) && guard < 2000) begin
      if (pool.size() > 0) drive(1, pool[0], 0, $urandom_range(0, 255), 1, 1);
      else drive(0, 0, 0, 0, 1, 1);
      guard++;
    end
    chk("drain_within_budget", 32'(guard < 2000), 32'd1);
    drive(0, 0, 0, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/retry_inorder_end.md
Name: retry_inorder_end

Overview:
- Terminating stage of the time-DMR retry loop. Sits directly downstream of time_DMR_end, and is an alternative to retry_end.
- Consumes the DMR-checked results (data, id, needs_retry, valid/ready).
- Sends failed IDs back to retry_start over the retry channel.
- Stores good results in an ID-indexed reorder buffer and releases them downstream strictly in ID-allocation order, so retries never reorder the output stream.

Parameters:
- DataType, logic, payload type carried through (opaque).
- IDSize, 4, width of the transaction ID; buffer depth is 2**IDSize entries.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_i  in  $bits(DataType)  result payload from time_DMR_end
- id_i  in  IDSize  transaction ID of data_i
- needs_retry_i  in  1  DMR mismatch; the transaction must be replayed
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  $bits(DataType)  in-order result
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_o  out  IDSize  ID to replay
- retry_valid_o  out  1  retry request valid
- retry_ready_i  in  1  retry_start accepts the request
- duplicate_o  out  1  one-cycle pulse: a good result arrived for an ID whose slot is already occupied

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset state:
  - occ[all] = 0, expected_id = 0, retry_valid_o = 0, retry_id_o = 0, duplicate_o = 0.
  - Hence valid_o = 0.
  - Buffer storage is not reset; it is never observed while its occ bit is 0.
- Handshake: valid/ready, AXI-style. A transfer happens when valid & ready are both high. Valid must not depend on ready.
- Upstream accept, good result (needs_retry_i = 0):
  - ready_o = !occ[id_i] && !(valid_o && ready_i && id_i == expected_id).
  - On transfer: mem[id_i] <= data_i, occ[id_i] <= 1.
- Upstream accept, retry (needs_retry_i = 1):
  - ready_o = !retry_valid_o || retry_ready_i.
  - On transfer: retry_id_o <= id_i, retry_valid_o <= 1. Data is discarded and the buffer is untouched.
- Retry register: single entry. It clears when retry_valid_o && retry_ready_i and no new retry is accepted in the same cycle. Accept-and-drain in the same cycle reloads it (no bubble).
- Output:
  - valid_o = occ[expected_id], data_o = mem[expected_id], both combinational from registers.
  - Minimum latency from accepted good result to valid_o is 1 cycle.
  - On valid_o && ready_i: occ[expected_id] <= 0, expected_id <= expected_id + 1, modulo 2**IDSize (wraps 2**IDSize-1 -> 0).
- Missing expected ID (lost or retrying): valid_o stays 0 (head-of-line block) while later IDs keep filling the buffer.
- Duplicate ID:
  - Occurs when valid_i && !needs_retry_i && occ[id_i] is already 1.
  - ready_o is low, so no transfer. duplicate_o pulses 1 in the following cycle for each cycle the condition holds.
  - Upstream stalls; this is an error indication only.
- Simultaneous release and write to the same slot: stalled for one cycle via the ready_o rule, so the buffer never overwrites live data.
- Simultaneous retry accept and output release: independent, both proceed.
- Capacity: upstream (time_DMR_start ID allocation) guarantees at most 2**IDSize transactions in flight. The block does not check ID aliasing beyond the occupancy/duplicate rule.
- Reset mid-operation: all buffered results and any pending retry are dropped. expected_id returns to 0 and outputs go to their reset values immediately (asynchronous).

Test Plan:
- In-order, no faults: IDs 0,1,2,3 with data 0xA0..0xA3, ready_i = 1 -> data_o = 0xA0..0xA3 on consecutive cycles, each 1 cycle after acceptance; retry_valid_o stays 0.
- Retry and reorder: ID0 good; ID1 needs_retry; ID2, ID3 good; then ID1 good -> retry_valid_o = 1 with retry_id_o = 1; output 0xA0, then stall; after ID1 returns, outputs 0xA1, 0xA2, 0xA3 back-to-back.
- Retry backpressure: retry_ready_i = 0 with one retry pending, second needs_retry arrives -> ready_o = 0 until retry_ready_i = 1; both IDs emitted in arrival order on retry_id_o.
- Downstream stall and wrap (IDSize = 4): ready_i = 0 while IDs 0..15 are accepted -> all occ set, ready_o = 0 for a reused ID0; release 16 results -> expected_id wraps to 0 and a new ID0 is accepted.
- Duplicate: ID5 good is buffered while expected_id = 3, then ID5 good again -> ready_o = 0 and duplicate_o = 1 the next cycle; buffer contents unchanged.
- Reset mid-stream: IDs 1, 2 buffered and a retry pending; assert rst_ni low -> valid_o = 0 and retry_valid_o = 0 immediately; after release, ID0 is output normally.
